// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the branch path: word width, condition codes
// and the sequencer state encoding.
package cpu_pkg;

   localparam int WORD_W = 16;

   localparam logic [3:0] COND_GT  = 4'b0000;
   localparam logic [3:0] COND_LT  = 4'b0001;
   localparam logic [3:0] COND_EQ  = 4'b0010;
   localparam logic [3:0] COND_NE  = 4'b0011;
   localparam logic [3:0] COND_Z   = 4'b0100;
   localparam logic [3:0] COND_NEG = 4'b0101;
   localparam logic [3:0] COND_GTN = 4'b1000;
   localparam logic [3:0] COND_LTN = 4'b1001;
   localparam logic [3:0] COND_EQN = 4'b1010;
   localparam logic [3:0] COND_NEN = 4'b1011;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      EVAL  = 2'd1,
      FLUSH = 2'd2
   } state_t;

endpackage

// File: rtl/branch_sequencer_if.sv
// Branch request channel from decode to the PC sequencer (valid/ready with operands).
interface branch_sequencer_if;
   import cpu_pkg::*;

   logic              br_valid;
   logic              br_ready;
   logic [3:0]        br_cond;
   logic [WORD_W-1:0] br_rd;
   logic [WORD_W-1:0] br_rs;
   logic [WORD_W-1:0] br_n;
   logic [WORD_W-1:0] br_target;

   modport master (
      output br_valid, br_cond, br_rd, br_rs, br_n, br_target,
      input  br_ready
   );

   modport slave (
      input  br_valid, br_cond, br_rd, br_rs, br_n, br_target,
      output br_ready
   );

endinterface

// File: rtl/branch_sequencer_cond.sv
// Combinational branch condition evaluator; all compares are unsigned 16-bit.
module branch_cond
   import cpu_pkg::*;
(
   input  logic [3:0]        cond,
   input  logic [WORD_W-1:0] rd,
   input  logic [WORD_W-1:0] rs,
   input  logic [WORD_W-1:0] n,
   output logic              taken
);

   always_comb begin
      taken = 1'b0;
      case (cond)
         COND_GT:  taken = (rd >  rs);
         COND_LT:  taken = (rd <  rs);
         COND_EQ:  taken = (rd == rs);
         COND_NE:  taken = (rd != rs);
         COND_Z:   taken = (rd == '0);
         COND_NEG: taken = rd[WORD_W-1];
         COND_GTN: taken = (rd >  n);
         COND_LTN: taken = (rd <  n);
         COND_EQN: taken = (rd == n);
         COND_NEN: taken = (rd != n);
         default:  taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_sequencer.sv
// PC sequencer for conditional jumps: accepts one branch at a time, resolves it
// a cycle later, then redirects the PC and holds flush for FLUSH_CYCLES cycles.
module branch_sequencer
   import cpu_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC     = 16'h0000,
   parameter int                FLUSH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   branch_sequencer_if.slave br,
   output logic [WORD_W-1:0] pc,
   output logic              taken,
   output logic              flush,
   output logic              busy
);

   localparam logic [3:0] FLUSH_INIT = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;

   state_t            state;
   logic [3:0]        flush_cnt;
   logic [3:0]        cond_p1;
   logic [WORD_W-1:0] rd_p1;
   logic [WORD_W-1:0] rs_p1;
   logic [WORD_W-1:0] n_p1;
   logic [WORD_W-1:0] target_p1;
   logic              hit_p1;

   assign br.br_ready = (state == RUN);
   assign busy        = (state != RUN);

   // stage p1: condition resolved from operands latched at acceptance
   branch_cond u_cond (
      .cond  (cond_p1),
      .rd    (rd_p1),
      .rs    (rs_p1),
      .n     (n_p1),
      .taken (hit_p1)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= RUN;
         pc        <= RESET_PC;
         taken     <= 1'b0;
         flush     <= 1'b0;
         flush_cnt <= 4'd0;
         cond_p1   <= 4'd0;
         rd_p1     <= '0;
         rs_p1     <= '0;
         n_p1      <= '0;
         target_p1 <= '0;
      end else begin
         taken <= 1'b0;
         case (state)
            RUN: begin
               if (br.br_valid) begin
                  cond_p1   <= br.br_cond;
                  rd_p1     <= br.br_rd;
                  rs_p1     <= br.br_rs;
                  n_p1      <= br.br_n;
                  target_p1 <= br.br_target;
                  state     <= EVAL;
               end else if (enable) begin
                  pc <= pc + 16'd1;
               end
            end
            EVAL: begin
               if (hit_p1) begin
                  pc    <= target_p1;
                  taken <= 1'b1;
                  if (FLUSH_CYCLES == 0) begin
                     state <= RUN;
                  end else begin
                     state     <= FLUSH;
                     flush     <= 1'b1;
                     flush_cnt <= FLUSH_INIT;
                  end
               end else begin
                  pc    <= pc + 16'd1;
                  state <= RUN;
               end
            end
            FLUSH: begin
               if (flush_cnt == 4'd0) begin
                  state <= RUN;
                  flush <= 1'b0;
               end else begin
                  flush_cnt <= flush_cnt - 4'd1;
               end
            end
            default: begin
               state <= RUN;
               flush <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer: expected branch outcomes are queued at
// issue and compared when the branch resolves.
module tb_branch_sequencer;
   import cpu_pkg::*;

   localparam int          FLUSH_CYCLES = 2;
   localparam logic [15:0] RESET_PC     = 16'h0000;

   typedef struct {
      logic        tk;
      logic [15:0] pc;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [15:0] pc;
   logic        taken;
   logic        flush;
   logic        busy;

   branch_sequencer_if bus ();

   branch_sequencer #(
      .RESET_PC     (RESET_PC),
      .FLUSH_CYCLES (FLUSH_CYCLES)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .enable (enable),
      .br     (bus.slave),
      .pc     (pc),
      .taken  (taken),
      .flush  (flush),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks = 0;
   int          failures = 0;
   logic [15:0] exp_pc;
   exp_t        sb[$];

   function automatic logic model_taken(input logic [3:0] c, input logic [15:0] rd,
                                        input logic [15:0] rs, input logic [15:0] n);
      logic [15:0] b;
      b = c[3] ? n : rs;
      if (c[3] && c[2]) return 1'b0;
      if (c[2]) begin
         if (c[1:0] == 2'd0) return (rd == 16'd0);
         if (c[1:0] == 2'd1) return rd[15];
         return 1'b0;
      end
      case (c[1:0])
         2'd0:    return rd > b;
         2'd1:    return rd < b;
         2'd2:    return rd == b;
         default: return rd != b;
      endcase
   endfunction

   // Called right after a negedge; leaves the bench right after a negedge.
   task automatic send_branch(input logic [3:0] c, input logic [15:0] rd, input logic [15:0] rs,
                              input logic [15:0] n, input logic [15:0] tgt, input string tag);
      exp_t e;
      e.tk = model_taken(c, rd, rs, n);
      e.pc = e.tk ? tgt : exp_pc + 16'd1;
      sb.push_back(e);
      bus.br_valid  = 1'b1;
      bus.br_cond   = c;
      bus.br_rd     = rd;
      bus.br_rs     = rs;
      bus.br_n      = n;
      bus.br_target = tgt;
      enable        = 1'b1;
      @(posedge clk);
      #1;
      bus.br_valid  = 1'b0;
      bus.br_cond   = ~c;
      bus.br_rd     = ~rd;
      bus.br_rs     = ~rs;
      bus.br_n      = ~n;
      bus.br_target = ~tgt;
      @(negedge clk);
      checks++;
      if (bus.br_ready !== 1'b0 || busy !== 1'b1 || pc !== exp_pc || taken !== 1'b0) begin
         failures++;
         $display("FAIL %s_eval ready=%b busy=%b pc=%h taken=%b required ready=0 busy=1 pc=%h taken=0",
                  tag, bus.br_ready, busy, pc, taken, exp_pc);
      end
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (pc !== e.pc || taken !== e.tk) begin
         failures++;
         $display("FAIL %s_resolve pc=%h taken=%b required pc=%h taken=%b", tag, pc, taken, e.pc, e.tk);
      end
      if (e.tk) begin
         for (int i = 0; i < FLUSH_CYCLES; i++) begin
            checks++;
            if (flush !== 1'b1 || bus.br_ready !== 1'b0 || pc !== e.pc || (i > 0 && taken !== 1'b0)) begin
               failures++;
               $display("FAIL %s_flush%0d flush=%b ready=%b pc=%h taken=%b required flush=1 ready=0 pc=%h",
                        tag, i, flush, bus.br_ready, pc, taken, e.pc);
            end
            @(posedge clk);
            @(negedge clk);
         end
      end
      checks++;
      if (bus.br_ready !== 1'b1 || busy !== 1'b0 || flush !== 1'b0 || taken !== 1'b0 || pc !== e.pc) begin
         failures++;
         $display("FAIL %s_done ready=%b busy=%b flush=%b taken=%b pc=%h required 1 0 0 0 pc=%h",
                  tag, bus.br_ready, busy, flush, taken, pc, e.pc);
      end
      exp_pc = e.pc;
      enable = 1'b0;
   endtask

   task automatic run_enable(input int cycles, input string tag);
      enable = 1'b1;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         @(negedge clk);
         exp_pc = exp_pc + 16'd1;
         checks++;
         if (pc !== exp_pc || busy !== 1'b0 || bus.br_ready !== 1'b1 || taken !== 1'b0 || flush !== 1'b0) begin
            failures++;
            $display("FAIL %s_step%0d pc=%h busy=%b ready=%b taken=%b flush=%b required pc=%h 0 1 0 0",
                     tag, i, pc, busy, bus.br_ready, taken, flush, exp_pc);
         end
      end
      enable = 1'b0;
   endtask

   task automatic test_reset();
      reset         = 1'b1;
      enable        = 1'b0;
      bus.br_valid  = 1'b0;
      bus.br_cond   = 4'd0;
      bus.br_rd     = 16'd0;
      bus.br_rs     = 16'd0;
      bus.br_n      = 16'd0;
      bus.br_target = 16'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (pc !== RESET_PC || taken !== 1'b0 || flush !== 1'b0 || busy !== 1'b0 || bus.br_ready !== 1'b1) begin
         failures++;
         $display("FAIL reset_state pc=%h taken=%b flush=%b busy=%b ready=%b required pc=%h 0 0 0 1",
                  pc, taken, flush, busy, bus.br_ready, RESET_PC);
      end
      reset  = 1'b0;
      exp_pc = RESET_PC;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (pc !== RESET_PC) begin
         failures++;
         $display("FAIL reset_hold pc=%h required %h", pc, RESET_PC);
      end
   endtask

   task automatic test_increment();
      run_enable(5, "incr");
   endtask

   task automatic test_taken_eq();
      run_enable(11, "to_0010");
      send_branch(COND_EQ, 16'h1234, 16'h1234, 16'h0000, 16'h0100, "eq_taken");
   endtask

   task automatic test_wrap();
      send_branch(COND_EQ, 16'h0005, 16'h0005, 16'h0000, 16'hFFFF, "to_ffff");
      run_enable(1, "wrap");
   endtask

   task automatic test_conds();
      logic [3:0]  c [12] = '{COND_GT, COND_NEG, 4'b0110, COND_NEN, COND_LT, COND_NE,
                              COND_Z, COND_NEG, COND_GTN, COND_LTN, COND_EQN, 4'b1111};
      logic [15:0] rd[12] = '{16'h8000, 16'h7FFF, 16'h0000, 16'h0005, 16'h0001, 16'h0003,
                              16'h0000, 16'h8000, 16'hFFFF, 16'h0002, 16'h0042, 16'h0000};
      logic [15:0] rs[12] = '{16'h0001, 16'h0000, 16'h0000, 16'h0009, 16'hFFFF, 16'h0003,
                              16'h1111, 16'h0000, 16'h0000, 16'h0000, 16'h0042, 16'h0000};
      logic [15:0] nn[12] = '{16'h0000, 16'h0000, 16'h0000, 16'h0005, 16'h0000, 16'h0000,
                              16'h0000, 16'h0000, 16'h7FFF, 16'h8000, 16'h0042, 16'h0000};
      for (int i = 0; i < 12; i++) begin
         send_branch(c[i], rd[i], rs[i], nn[i], 16'h0200 + 16'(i * 16), $sformatf("cond%0d", i));
      end
   endtask

   task automatic test_back_to_back();
      send_branch(COND_NE, 16'h0001, 16'h0001, 16'h0000, 16'h0300, "b2b_nt0");
      send_branch(COND_EQN, 16'h0001, 16'h0000, 16'h0002, 16'h0310, "b2b_nt1");
      send_branch(COND_LT, 16'h0001, 16'h0002, 16'h0000, 16'h0320, "b2b_tk");
      send_branch(COND_Z, 16'h0000, 16'h0000, 16'h0000, exp_pc, "self_target");
      run_enable(2, "after_b2b");
   endtask

   task automatic test_reset_in_flush();
      bus.br_valid  = 1'b1;
      bus.br_cond   = COND_EQ;
      bus.br_rd     = 16'h0001;
      bus.br_rs     = 16'h0001;
      bus.br_target = 16'h0ABC;
      enable        = 1'b1;
      @(posedge clk);
      #1 bus.br_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (flush !== 1'b1 || pc !== 16'h0ABC) begin
         failures++;
         $display("FAIL rif_pre flush=%b pc=%h required flush=1 pc=0abc", flush, pc);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (pc !== RESET_PC || flush !== 1'b0 || taken !== 1'b0 || bus.br_ready !== 1'b1 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rif_async pc=%h flush=%b taken=%b ready=%b busy=%b required pc=%h 0 0 1 0",
                  pc, flush, taken, bus.br_ready, busy, RESET_PC);
      end
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      enable = 1'b0;
      checks++;
      if (pc !== RESET_PC + 16'd1 || flush !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL rif_first_step pc=%h flush=%b busy=%b required pc=%h 0 0",
                  pc, flush, busy, RESET_PC + 16'd1);
      end
      exp_pc = RESET_PC + 16'd1;
   endtask

   initial begin
      test_reset();
      test_increment();
      test_taken_eq();
      test_wrap();
      test_conds();
      test_back_to_back();
      test_reset_in_flush();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain left=%0d required 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Program-counter sequencer for the CPU's conditional-jump path. It owns the 16-bit PC and accepts one branch request at a time over a valid/ready handshake. It latches the request operands, evaluates the 4-bit jump condition one cycle later, then redirects the PC and flushes the pipeline when the branch is taken. It sits between the decode stage, which issues branch requests, and instruction fetch, which consumes `pc` and `flush`.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `FLUSH_CYCLES`, 2, number of cycles `flush` is held after a taken branch (0–15; 0 means no flush state).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `enable`  in  1  PC advance enable; low stalls sequential increment in RUN.
- `br_valid`  in  1  branch request valid.
- `br_ready`  out  1  sequencer can accept a request.
- `br_cond`  in  4  condition code.
- `br_rd`, `br_rs`, `br_n`  in  16 each  compare operands: register, register, immediate.
- `br_target`  in  16  jump target.
- `pc`  out  16  current program counter.
- `taken`  out  1  one-cycle pulse when a branch resolves taken.
- `flush`  out  1  fetch/decode flush.
- `busy`  out  1  high whenever state ≠ RUN.

## Operation
- States: RUN, EVAL, FLUSH.
- **RUN**
  - `br_ready` = 1.
  - If `br_valid` is high, the request is accepted independent of `enable`:
    - latch cond/rd/rs/n/target;
    - PC holds;
    - go to EVAL.
  - Otherwise, if `enable` is high: pc <= pc + 1, modulo 2^16 (16'hFFFF wraps to 16'h0000).
- **EVAL**
  - `br_ready` = 0. `enable` is ignored.
  - Evaluate the latched condition (all compares unsigned, 16-bit):
    - 0000: rd > rs
    - 0001: rd < rs
    - 0010: rd == rs
    - 0011: rd != rs
    - 0100: rd == 0
    - 0101: rd[15] == 1
    - 1000: rd > n
    - 1001: rd < n
    - 1010: rd == n
    - 1011: rd != n
    - all other codes: not taken.
  - Taken:
    - pc <= target;
    - `taken` pulses for one cycle;
    - go to FLUSH, or to RUN if FLUSH_CYCLES = 0.
  - Not taken: pc <= pc + 1; go to RUN.
- **FLUSH**
  - `flush` = 1 and PC holds.
  - A 4-bit down-counter, loaded with FLUSH_CYCLES−1 on entry, sets the duration.
  - Exit to RUN when the counter is 0 in FLUSH.
  - `br_valid` is ignored because `br_ready` = 0.
- Outputs are registered, except that `br_ready` and `busy` decode directly from the state register.
- Reset at any time, including mid-EVAL or mid-FLUSH:
  - state = RUN;
  - pc = RESET_PC;
  - `taken` = 0, `flush` = 0, `busy` = 0, `br_ready` = 1;
  - latched operands and the counter are cleared;
  - any in-flight request is discarded.

## Timing
- Request accepted at edge k. EVAL occupies cycle k..k+1. The new pc is visible after edge k+1.
- `taken` is high for exactly the cycle after edge k+1.
- `flush` is high for FLUSH_CYCLES consecutive cycles starting after edge k+1. `br_ready` returns 1 in the following cycle.
- Not-taken branch: one-cycle bubble; pc = old pc + 1 after edge k+1; `br_ready` is back to 1 after edge k+1.
- Back-to-back requests: the earliest next acceptance is the first RUN cycle. Throughput is 1 branch per 2 cycles when not taken, and per 2+FLUSH_CYCLES cycles when taken.
- Taken to the current pc value is legal. pc reloads the same value and the flush still occurs.

## Structure
- Shared package `cpu_pkg` holds:
  - condition-code constants COND_GT, COND_LT, COND_EQ, COND_NE, COND_Z, COND_NEG, COND_GTN, COND_LTN, COND_EQN, COND_NEN;
  - the state enum {RUN, EVAL, FLUSH};
  - the 16-bit word width.
- One combinational sub-module, `branch_cond`, maps (cond, rd, rs, n) to taken. It is instantiated on the latched operands. The FSM, PC register and flush counter are in the top level.

## Test plan
- Reset, then `enable` = 1 for 5 cycles with no requests -> pc goes 0,1,2,3,4,5; `busy` = 0; `br_ready` = 1 throughout.
- pc = 16'hFFFF, `enable` = 1 -> pc = 16'h0000 next cycle; no `taken`, no `flush`.
- At pc = 16'h0010, request cond 0010 with rd = rs = 16'h1234, target = 16'h0100, FLUSH_CYCLES = 2 -> pc = 16'h0100 after 2 edges; `taken` high for 1 cycle; `flush` high for 2 cycles; `br_ready` low for 3 cycles.
- Request cond 0000 with rd = 16'h8000, rs = 16'h0001 -> taken (unsigned). Request cond 0101 with rd = 16'h7FFF -> not taken; pc = old + 1; one-cycle bubble.
- Request cond 0110 (undefined) with any operands -> not taken. Request cond 1011 with rd = 5, n = 5 -> not taken.
- Assert `reset` during the FLUSH cycle of a taken branch -> pc = RESET_PC immediately (asynchronous); `flush` = 0; `br_ready` = 1; first post-reset `enable` cycle gives pc = RESET_PC + 1.
